prbs_checker_wide: RTL and testbench
====================================

PRBS_CHECKER_WIDE -- requirements
Module: prbs_checker_wide

Interface
REQ-001 SHALL have parameter PN, default 7, meaning LFSR order; legal values 3,4,5,6,7,9,11,15,17,23,31, taps as in the team PRBS generator.
REQ-002 SHALL have parameter WIDTH, default 16, meaning bits per word; WIDTH >= PN is required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have parameter LOCK_CNT, default 4, meaning consecutive error-free words needed to declare lock.
REQ-004 SHALL have parameter LOSS_CNT, default 4, meaning consecutive errored words needed to drop lock.
REQ-005 SHALL have parameter CNT_W, default 32, meaning width of the saturating error and word counters.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port i_a_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_data, input, WIDTH, the received PRBS word; bit WIDTH-1 is the oldest bit, matching generator order.
REQ-009 SHALL have port i_valid, input, 1; i_data is consumed only when it is high.
REQ-010 SHALL have port i_clr_cnt, input, 1, a synchronous clear of o_err_cnt and o_word_cnt.
REQ-011 SHALL have port o_locked, output, 1, high in state LOCKED.
REQ-012 SHALL have port o_err, output, 1, a one-cycle pulse when a word checked in LOCKED has at least one bit error.
REQ-013 SHALL have port o_err_bits, output, $clog2(WIDTH+1), the popcount of mismatches in the last checked word.
REQ-014 SHALL have port o_err_cnt, output, CNT_W, the accumulated bit errors while LOCKED, saturating.
REQ-015 SHALL have port o_word_cnt, output, CNT_W, the words checked while LOCKED, saturating.

Function
REQ-016 SHALL implement an FSM with states UNLOCKED, SYNC and LOCKED, advancing only on i_valid=1.
REQ-017 SHALL, in UNLOCKED on a valid word, seed the LFSR with i_data[PN-1:0] (i_data[0] is the newest bit), clear the match counter and go to SYNC.
REQ-018 SHALL, in SYNC and LOCKED, form the expected word by stepping the LFSR WIDTH times using the generator recurrence, and compare it with i_data.
REQ-019 SHALL, in SYNC, on a match increment the match counter and enter LOCKED when it reaches LOCK_CNT; on any mismatch go to UNLOCKED and reseed from that word in the same cycle.
REQ-020 SHALL, in LOCKED, advance the LFSR to the predicted state regardless of errors, so errors do not propagate.
REQ-021 SHALL, in LOCKED, clear the loss counter on an error-free word and increment it on an errored word; on reaching LOSS_CNT it SHALL go to UNLOCKED and deassert o_locked.
REQ-022 SHALL register o_err, o_err_bits and the counters one cycle after the valid word (latency 1), with o_locked changing in the same cycle as the FSM state.
REQ-023 SHALL drive o_err low and hold o_err_bits when i_valid=0 or the state is not LOCKED.
REQ-024 SHALL saturate o_err_cnt and o_word_cnt at all-ones, with no wrap-around.
REQ-025 SHALL, when i_clr_cnt coincides with a checked word, load o_err_cnt with that word's popcount and o_word_cnt with 1; clear has priority over old contents.
REQ-026 SHALL have all LFSR steps be combinational within one cycle, with no multicycle paths.

Reset
REQ-027 SHALL, on i_a_rst_n low, take state UNLOCKED, LFSR all ones, all counters 0, o_locked 0, o_err 0, o_err_bits 0, o_err_cnt 0 and o_word_cnt 0, immediately and asynchronously.
REQ-028 SHALL, after reset release mid-stream, restart acquisition; it SHALL NOT retain lock across reset.

Structure
REQ-029 SHALL take TAP_1/TAP_0 selection functions and the FSM state enum from a shared package, prbs_pkg, which the generator also uses.
REQ-030 SHALL place LFSR stepping in one combinational sub-module, prbs_next_word (PN, WIDTH; lfsr in -> word out, lfsr out), reusable by the generator.

Verification
REQ-031 SHALL be verified with PN=7, WIDTH=16 and a clean generator stream into i_data: o_locked rises after 1 seed word plus 4 matching words, and o_err_cnt stays 0 over 1000 words.
REQ-032 SHALL be verified by flipping bit 3 in one word while locked: o_err pulses once, o_err_bits=1, o_err_cnt=1, lock is held, and the next word shows 0 errors.
REQ-033 SHALL be verified by inverting all bits for 4 consecutive words while locked: o_err_bits=16 each, o_err_cnt=64, o_locked falls after the 4th, and lock reacquires on the clean stream.
REQ-034 SHALL be verified by toggling i_valid randomly at 50%: lock timing counts only valid words and no errors occur.
REQ-035 SHALL be verified by preloading the counter to 32'hFFFF_FFF0 (force, CNT_W=32) with errors injected: o_err_cnt sticks at 32'hFFFF_FFFF; then i_clr_cnt with a 2-bit-error word gives o_err_cnt=2 and o_word_cnt=1.
REQ-036 SHALL be verified by asserting i_a_rst_n low mid-lock between clock edges: all outputs reach 0 before the next edge, and relock happens 5 valid words after release.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: tap selection per LFSR order and the checker FSM states.
// Used by both the PRBS generator and the PRBS checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } prbs_state_e;

  // Polynomial x^tap_1 + x^tap_0 + 1; a return of 0 marks an unsupported order.
  function automatic int tap_1(input int pn);
    return pn;
  endfunction

  function automatic int tap_0(input int pn);
    case (pn)
      3:       return 2;
      4:       return 3;
      5:       return 3;
      6:       return 5;
      7:       return 6;
      9:       return 5;
      11:      return 9;
      15:      return 14;
      17:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/prbs_next_word.sv
// Steps a Fibonacci LFSR WIDTH times in one cycle; word[WIDTH-1] is the first (oldest) bit.
// lfsr_in[0] is the newest bit of history, lfsr_in[PN-1] the oldest.
module prbs_next_word
  import prbs_pkg::*;
#(
  parameter int PN    = 7,
  parameter int WIDTH = 16
) (
  input  logic [PN-1:0]    lfsr_in,
  output logic [WIDTH-1:0] word,
  output logic [PN-1:0]    lfsr_out
);

  localparam int T1 = tap_1(PN);
  localparam int T0 = tap_0(PN);

  logic [PN-1:0] state;
  logic          new_bit;

  // NOTE: blocking assignments here are deliberate; each loop pass must see the
  // state produced by the previous pass within the same evaluation.
  always_comb begin
    state   = lfsr_in;
    new_bit = 1'b0;
    word    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_bit           = state[T1-1] ^ state[T0-1];
      word[WIDTH-1-i]   = new_bit;
      state             = {state[PN-2:0], new_bit};
    end
    lfsr_out = state;
  end

endmodule

// File: rtl/prbs_checker_wide.sv
// Word-wide PRBS checker: acquires lock on a received PRBS stream, then counts
// bit errors against a free-running local prediction.
module prbs_checker_wide
  import prbs_pkg::*;
#(
  parameter int PN       = 7,
  parameter int WIDTH    = 16,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 32
) (
  input  logic                       i_clk,
  input  logic                       i_a_rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  input  logic                       i_clr_cnt,
  output logic                       o_locked,
  output logic                       o_err,
  output logic [$clog2(WIDTH+1)-1:0] o_err_bits,
  output logic [CNT_W-1:0]           o_err_cnt,
  output logic [CNT_W-1:0]           o_word_cnt
);

  localparam int EB_W    = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_CNT + 1);

  if (WIDTH < PN) begin : g_width_check
    $error("prbs_checker_wide: WIDTH must be at least PN");
  end
  if (tap_0(PN) == 0) begin : g_pn_check
    $error("prbs_checker_wide: unsupported PN");
  end

  prbs_state_e        state_q, state_d;
  logic [PN-1:0]      lfsr_q, lfsr_d, lfsr_pred;
  logic [WIDTH-1:0]   exp_word, diff;
  logic [EB_W-1:0]    pop;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               checked;
  logic               err_q;
  logic [EB_W-1:0]    err_bits_q;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d, word_cnt_q, word_cnt_d;
  logic [CNT_W:0]     err_sum;

  prbs_next_word #(.PN(PN), .WIDTH(WIDTH)) u_next (
    .lfsr_in  (lfsr_q),
    .word     (exp_word),
    .lfsr_out (lfsr_pred)
  );

  assign diff    = exp_word ^ i_data;
  assign checked = i_valid && (state_q == ST_LOCKED);

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + EB_W'(diff[i]);
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    match_d = match_q;
    loss_d  = loss_q;
    if (i_valid) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          lfsr_d  = i_data[PN-1:0];
          match_d = '0;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (diff == '0) begin
            lfsr_d  = lfsr_pred;
            match_d = match_q + MATCH_W'(1);
            if (match_d == MATCH_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              loss_d  = '0;
            end
          end else begin
            lfsr_d  = i_data[PN-1:0];
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          // Always follow the prediction so a corrupted word never poisons the LFSR.
          lfsr_d = lfsr_pred;
          if (diff == '0) begin
            loss_d = '0;
          end else begin
            loss_d = loss_q + LOSS_W'(1);
            if (loss_d == LOSS_W'(LOSS_CNT)) state_d = ST_UNLOCKED;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  assign err_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(pop);

  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (i_clr_cnt) begin
      err_cnt_d  = checked ? CNT_W'(pop) : '0;
      word_cnt_d = checked ? CNT_W'(1) : '0;
    end else if (checked) begin
      err_cnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      state_q    <= ST_UNLOCKED;
      lfsr_q     <= '1;
      match_q    <= '0;
      loss_q     <= '0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      match_q    <= match_d;
      loss_q     <= loss_d;
      err_q      <= checked && (diff != '0);
      if (checked) err_bits_q <= pop;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_locked   = (state_q == ST_LOCKED);
  assign o_err      = err_q;
  assign o_err_bits = err_bits_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs_checker_wide.sv
// Bench for prbs_checker_wide (PN=7, WIDTH=16): a bit-history PRBS source feeds the
// checker and a bit-history reference model predicts lock state and error counts.
module tb_prbs_checker_wide;

  localparam int     PN      = 7;
  localparam int     TAP0    = 6;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_clr_cnt = 1'b0;
  logic        o_locked, o_err;
  logic [4:0]  o_err_bits;
  logic [31:0] o_err_cnt, o_word_cnt;

  int total = 0;
  int bad   = 0;

  // Source: full bit history, s[n] = s[n-7] ^ s[n-6].
  bit gen_seq[$];
  // Reference model state.
  bit     m_hist[$];
  int     m_mode;   // 0 acquiring, 1 verifying, 2 locked
  int     m_run;
  bit     m_locked, m_err;
  int     m_err_bits;
  longint m_err_cnt, m_word_cnt;

  prbs_checker_wide #(
    .PN(7), .WIDTH(16), .LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(32)
  ) dut (
    .i_clk      (clk),
    .i_a_rst_n  (rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_clr_cnt  (i_clr_cnt),
    .o_locked   (o_locked),
    .o_err      (o_err),
    .o_err_bits (o_err_bits),
    .o_err_cnt  (o_err_cnt),
    .o_word_cnt (o_word_cnt)
  );

  always #5 clk = ~clk;

  task automatic gen_next(output logic [15:0] w);
    int n;
    bit b;
    for (int i = 0; i < 16; i++) begin
      n = gen_seq.size();
      b = gen_seq[n-PN] ^ gen_seq[n-TAP0];
      gen_seq.push_back(b);
      w[15-i] = b;
    end
    while (gen_seq.size() > 64) void'(gen_seq.pop_front());
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_locked = 0; m_err = 0; m_err_bits = 0;
    m_err_cnt = 0; m_word_cnt = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input logic [15:0] d, input logic v, input logic c);
    int  mism, n;
    bit  p, chk;
    mism = 0;
    chk  = v && (m_mode == 2);
    m_err = 0;
    if (v) begin
      if (m_mode != 0) begin
        for (int i = 0; i < 16; i++) begin
          n = m_hist.size();
          p = m_hist[n-PN] ^ m_hist[n-TAP0];
          m_hist.push_back(p);
          if (p != d[15-i]) mism++;
        end
      end
      case (m_mode)
        0: begin
          m_hist.delete();
          for (int i = 15; i >= 0; i--) m_hist.push_back(d[i]);
          m_mode = 1; m_run = 0;
        end
        1: begin
          if (mism == 0) begin
            m_run++;
            if (m_run == 4) begin m_mode = 2; m_run = 0; end
          end else m_mode = 0;
        end
        default: begin
          m_err      = (mism != 0);
          m_err_bits = mism;
          if (c) begin
            m_err_cnt = mism; m_word_cnt = 1;
          end else begin
            m_err_cnt  = (m_err_cnt + mism > CNT_MAX) ? CNT_MAX : m_err_cnt + mism;
            m_word_cnt = (m_word_cnt + 1 > CNT_MAX) ? CNT_MAX : m_word_cnt + 1;
          end
          m_run = (mism == 0) ? 0 : m_run + 1;
          if (m_run == 4) begin m_mode = 0; m_run = 0; end
        end
      endcase
      while (m_hist.size() > 64) void'(m_hist.pop_front());
    end
    if (c && !chk) begin m_err_cnt = 0; m_word_cnt = 0; end
    m_locked = (m_mode == 2);
  endtask

  // Drives one cycle of inputs, then leaves time at posedge+1 for sampling.
  task automatic drive(input logic [15:0] d, input logic v, input logic c);
    @(negedge clk);
    i_data = d; i_valid = v; i_clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(d, v, c);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; i_valid = 1'b0; i_clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", o_locked); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", o_err); end
    total++; if (o_err_bits !== 5'd0) begin bad++; $display("FAIL reset_err_bits got=%0d want=0", o_err_bits); end
    total++; if (o_err_cnt !== 32'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d want=0", o_err_cnt); end
    total++; if (o_word_cnt !== 32'd0) begin bad++; $display("FAIL reset_word_cnt got=%0d want=0", o_word_cnt); end
  endtask

  task automatic test_acquire();
    logic [15:0] w;
    int lock_at = 0;
    for (int k = 1; k <= 1000; k++) begin
      gen_next(w);
      drive(w, 1'b1, 1'b0);
      if (o_locked === 1'b1 && lock_at == 0) lock_at = k;
      total++;
      if (o_locked !== m_locked || o_err_cnt !== 32'(m_err_cnt)) begin
        bad++;
        $display("FAIL acquire_word%0d locked=%0b cnt=%0d want locked=%0b cnt=%0d",
                 k, o_locked, o_err_cnt, m_locked, m_err_cnt);
      end
    end
    total++; if (lock_at != 5) begin bad++; $display("FAIL acquire_latency got=%0d want=5", lock_at); end
    total++; if (o_err_cnt !== 32'd0) begin bad++; $display("FAIL acquire_err_cnt got=%0d want=0", o_err_cnt); end
    total++; if (o_word_cnt !== 32'(m_word_cnt)) begin bad++; $display("FAIL acquire_word_cnt got=%0d want=%0d", o_word_cnt, m_word_cnt); end
  endtask

  task automatic test_single_bit();
    logic [15:0] w;
    gen_next(w);
    drive(w ^ 16'h0008, 1'b1, 1'b0);
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL flip_err got=%0b want=1", o_err); end
    total++; if (o_err_bits !== 5'd1) begin bad++; $display("FAIL flip_err_bits got=%0d want=1", o_err_bits); end
    total++; if (o_err_cnt !== 32'd1 || o_err_cnt !== 32'(m_err_cnt)) begin bad++; $display("FAIL flip_err_cnt got=%0d want=1", o_err_cnt); end
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL flip_lock_held got=%0b want=1", o_locked); end
    drive(16'($urandom), 1'b0, 1'b0);
    total++; if (o_err !== 1'b0 || o_err_bits !== 5'd1) begin bad++; $display("FAIL flip_idle err=%0b bits=%0d want err=0 bits=1", o_err, o_err_bits); end
    gen_next(w);
    drive(w, 1'b1, 1'b0);
    total++; if (o_err !== 1'b0 || o_err_bits !== 5'd0) begin bad++; $display("FAIL flip_next err=%0b bits=%0d want err=0 bits=0", o_err, o_err_bits); end
    total++; if (o_err_cnt !== 32'(m_err_cnt)) begin bad++; $display("FAIL flip_next_cnt got=%0d want=%0d", o_err_cnt, m_err_cnt); end
  endtask

  task automatic test_loss();
    logic [15:0] w;
    int relock = 0;
    gen_next(w);
    drive(w, 1'b1, 1'b1);
    total++; if (o_err_cnt !== 32'd0 || o_word_cnt !== 32'd1) begin bad++; $display("FAIL loss_clear cnt=%0d words=%0d want 0/1", o_err_cnt, o_word_cnt); end
    for (int k = 1; k <= 4; k++) begin
      gen_next(w);
      drive(~w, 1'b1, 1'b0);
      total++; if (o_err_bits !== 5'd16) begin bad++; $display("FAIL loss_bits%0d got=%0d want=16", k, o_err_bits); end
      total++; if (o_locked !== m_locked || o_locked !== (k < 4)) begin bad++; $display("FAIL loss_locked%0d got=%0b want=%0b", k, o_locked, m_locked); end
    end
    total++; if (o_err_cnt !== 32'd64) begin bad++; $display("FAIL loss_err_cnt got=%0d want=64", o_err_cnt); end
    for (int k = 1; k <= 20 && relock == 0; k++) begin
      gen_next(w);
      drive(w, 1'b1, 1'b0);
      if (o_locked === 1'b1) relock = k;
    end
    total++; if (relock != 5) begin bad++; $display("FAIL loss_relock got=%0d words want=5", relock); end
  endtask

  task automatic test_valid_toggle();
    logic [15:0] w;
    logic        v;
    int vcount = 0, lock_v = 0;
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      v = 1'($urandom_range(0, 1));
      if (v) gen_next(w); else w = 16'($urandom);
      drive(w, v, 1'b0);
      if (v) vcount++;
      if (o_locked === 1'b1 && lock_v == 0) lock_v = vcount;
      total++;
      if (o_locked !== m_locked || o_err !== m_err) begin
        bad++;
        $display("FAIL toggle_cycle%0d locked=%0b err=%0b want locked=%0b err=%0b", k, o_locked, o_err, m_locked, m_err);
      end
    end
    total++; if (lock_v != 5) begin bad++; $display("FAIL toggle_latency got=%0d valid words want=5", lock_v); end
    total++; if (o_err_cnt !== 32'd0) begin bad++; $display("FAIL toggle_err_cnt got=%0d want=0", o_err_cnt); end
  endtask

  task automatic test_saturation();
    logic [15:0] w;
    force dut.err_cnt_q = 32'hFFFF_FFF0;
    drive(16'($urandom), 1'b0, 1'b0);
    release dut.err_cnt_q;
    m_err_cnt = 64'hFFFF_FFF0;
    for (int k = 0; k < 8; k++) begin
      gen_next(w);
      drive(w ^ 16'h0221, 1'b1, 1'b0);
      total++; if (o_err_cnt !== 32'(m_err_cnt)) begin bad++; $display("FAIL sat_step%0d got=%h want=%h", k, o_err_cnt, m_err_cnt); end
      gen_next(w);
      drive(w, 1'b1, 1'b0);
    end
    total++; if (o_err_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_stick got=%h want=ffffffff", o_err_cnt); end
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL sat_locked got=%0b want=1", o_locked); end
    gen_next(w);
    drive(w ^ 16'h0180, 1'b1, 1'b1);
    total++; if (o_err_cnt !== 32'd2 || o_word_cnt !== 32'd1) begin bad++; $display("FAIL sat_clear cnt=%0d words=%0d want 2/1", o_err_cnt, o_word_cnt); end
    total++; if (o_err_bits !== 5'd2) begin bad++; $display("FAIL sat_clear_bits got=%0d want=2", o_err_bits); end
  endtask

  task automatic test_async_reset();
    logic [15:0] w;
    int relock = 0;
    gen_next(w);
    drive(w ^ 16'h0001, 1'b1, 1'b0);
    total++; if (o_err !== 1'b1 || o_locked !== 1'b1) begin bad++; $display("FAIL arst_pre err=%0b locked=%0b want 1/1", o_err, o_locked); end
    @(negedge clk);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_locked !== 1'b0 || o_err !== 1'b0 || o_err_bits !== 5'd0 || o_err_cnt !== 32'd0 || o_word_cnt !== 32'd0) begin
      bad++;
      $display("FAIL arst_outputs locked=%0b err=%0b bits=%0d cnt=%0d words=%0d want all 0",
               o_locked, o_err, o_err_bits, o_err_cnt, o_word_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 20 && relock == 0; k++) begin
      gen_next(w);
      drive(w, 1'b1, 1'b0);
      if (o_locked === 1'b1) relock = k;
    end
    total++; if (relock != 5) begin bad++; $display("FAIL arst_relock got=%0d words want=5", relock); end
  endtask

  initial begin
    for (int i = 0; i < PN; i++) gen_seq.push_back(1'b1);
    model_reset();
    test_reset();
    test_acquire();
    test_single_bit();
    test_loss();
    test_valid_toggle();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
